// File: rtl/huffman_decode_ctrl.sv
// huffman_decode_ctrl
//   Sequences Huffman decoding of one granule/channel's part3 bits. Bits are
//   streamed from the bitstream buffer into the selected pair table (big-values
//   region) and then into the count1 quad table. Each decoded value is emitted
//   as a sample. The granule is zero-filled up to NUM_SAMPLES, and done then
//   pulses for one cycle.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    1-cycle pulse; latches side info (only in IDLE)
//   big_values               pairs in big-values region (clamped to 288)
//   table_sel0/1/2           pair table for region 0/1/2
//   region1_start/2_start    first sample index of region 1/2
//   count1_sel               quad table select, latched and driven on q_sel
//   part3_len                Huffman bit budget
//   bit_valid, bit_data      bitstream buffer interface; bit_ready = consumed
//   ht_sel, ht_axiiv/axiid   pair-table bank select and bit feed
//   ht_axiov, ht_x, ht_y     pair-table codeword complete + decoded pair
//   q_sel, q_axiiv/axiid     quad-table select and bit feed
//   q_axiov, q_vwxy          quad codeword complete + v,w,x,y ([3]=v .. [0]=y)
//   sample_valid/ready       sample handshake; sample_idx, sample_val payload
//   done                     1-cycle pulse after the last sample is accepted
//   bits_used                Huffman bits consumed this granule
module huffman_decode_ctrl #(
    parameter int unsigned NUM_SAMPLES = 576,
    parameter int unsigned SAMPLE_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8:0]          big_values,
    input  logic [4:0]          table_sel0,
    input  logic [4:0]          table_sel1,
    input  logic [4:0]          table_sel2,
    input  logic [9:0]          region1_start,
    input  logic [9:0]          region2_start,
    input  logic                count1_sel,
    input  logic [11:0]         part3_len,
    input  logic                bit_valid,
    input  logic                bit_data,
    output logic                bit_ready,
    output logic [4:0]          ht_sel,
    output logic                ht_axiiv,
    output logic                ht_axiid,
    input  logic                ht_axiov,
    input  logic [15:0]         ht_x,
    input  logic [15:0]         ht_y,
    output logic                q_sel,
    output logic                q_axiiv,
    output logic                q_axiid,
    input  logic                q_axiov,
    input  logic [3:0][1:0]     q_vwxy,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic [9:0]          sample_idx,
    output logic [SAMPLE_W-1:0] sample_val,
    output logic                done,
    output logic [11:0]         bits_used
);

    localparam logic [9:0] N_SAMP     = 10'(NUM_SAMPLES);
    localparam logic [9:0] LAST_IDX   = 10'(NUM_SAMPLES - 1);
    localparam logic [9:0] QUAD_LIMIT = 10'(NUM_SAMPLES - 4);
    localparam logic [8:0] MAX_PAIRS  = 9'(NUM_SAMPLES / 2);

    typedef enum logic [2:0] {
        S_IDLE, S_BIG, S_EMIT_X, S_EMIT_Y, S_COUNT1, S_EMIT_Q, S_ZERO, S_DONE
    } state_t;

    state_t                 state_q;
    logic [8:0]             bv_q;
    logic [8:0]             pairs_q;
    logic [4:0]             t0_q, t1_q, t2_q;
    logic [9:0]             r1_q, r2_q;
    logic [11:0]            p3_q;
    logic [11:0]            bits_q;
    logic [9:0]             idx_q;
    logic [SAMPLE_W-1:0]    y_q;
    logic [3:0][1:0]        quad_q;
    logic [1:0]             qcnt_q;
    logic                   qbusy_q;
    logic                   sample_valid_q;
    logic [9:0]             sample_idx_q;
    logic [SAMPLE_W-1:0]    sample_val_q;
    logic                   done_q;
    logic [4:0]             ht_sel_q;
    logic                   q_sel_q;

    logic                   overrun;
    logic                   q_exit;
    logic                   ht_feed;
    logic                   q_feed;
    logic [1:0]             qnext;

    function automatic logic [4:0] pick_tbl(input logic [9:0] i,
                                            input logic [9:0] r1, input logic [9:0] r2,
                                            input logic [4:0] a, input logic [4:0] b,
                                            input logic [4:0] c);
        if (i < r1)      return a;
        else if (i < r2) return b;
        else             return c;
    endfunction

    function automatic logic [SAMPLE_W-1:0] sext2(input logic [1:0] v);
        return {{(SAMPLE_W-2){v[1]}}, v};
    endfunction

    always_comb begin
        overrun = bits_q > p3_q;
        // Budget/space checks apply only between quad codewords; a quad already
        // in flight is allowed to finish so it can be judged (and discarded).
        q_exit  = ~qbusy_q & ((bits_q >= p3_q) | (idx_q > QUAD_LIMIT));
        ht_feed = bit_valid & (state_q == S_BIG) & ~ht_axiov & ~overrun & (ht_sel_q != 5'd0);
        q_feed  = bit_valid & (state_q == S_COUNT1) & ~q_axiov & ~q_exit;
        qnext   = qcnt_q + 2'd1;
    end

    assign bit_ready    = ht_feed | q_feed;
    assign ht_axiiv     = ht_feed;
    assign ht_axiid     = bit_data;
    assign q_axiiv      = q_feed;
    assign q_axiid      = bit_data;
    assign ht_sel       = ht_sel_q;
    assign q_sel        = q_sel_q;
    assign sample_valid = sample_valid_q;
    assign sample_idx   = sample_idx_q;
    assign sample_val   = sample_val_q;
    assign done         = done_q;
    assign bits_used    = bits_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            bv_q           <= '0;
            pairs_q        <= '0;
            t0_q           <= '0;
            t1_q           <= '0;
            t2_q           <= '0;
            r1_q           <= '0;
            r2_q           <= '0;
            p3_q           <= '0;
            bits_q         <= '0;
            idx_q          <= '0;
            y_q            <= '0;
            quad_q         <= '0;
            qcnt_q         <= '0;
            qbusy_q        <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_idx_q   <= '0;
            sample_val_q   <= '0;
            done_q         <= 1'b0;
            ht_sel_q       <= '0;
            q_sel_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bit_ready) bits_q <= bits_q + 12'd1;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        bv_q     <= (big_values > MAX_PAIRS) ? MAX_PAIRS : big_values;
                        t0_q     <= table_sel0;
                        t1_q     <= table_sel1;
                        t2_q     <= table_sel2;
                        r1_q     <= region1_start;
                        r2_q     <= region2_start;
                        p3_q     <= part3_len;
                        q_sel_q  <= count1_sel;
                        bits_q   <= '0;
                        idx_q    <= '0;
                        pairs_q  <= '0;
                        qbusy_q  <= 1'b0;
                        ht_sel_q <= pick_tbl(10'd0, region1_start, region2_start,
                                             table_sel0, table_sel1, table_sel2);
                        state_q  <= (big_values == 9'd0) ? S_COUNT1 : S_BIG;
                    end
                end

                S_BIG: begin
                    if (overrun) begin
                        state_q <= S_ZERO;
                    end else if (ht_sel_q == 5'd0) begin
                        sample_valid_q <= 1'b1;
                        sample_idx_q   <= idx_q;
                        sample_val_q   <= '0;
                        y_q            <= '0;
                        state_q        <= S_EMIT_X;
                    end else if (ht_axiov) begin
                        sample_valid_q <= 1'b1;
                        sample_idx_q   <= idx_q;
                        sample_val_q   <= SAMPLE_W'($signed(ht_x));
                        y_q            <= SAMPLE_W'($signed(ht_y));
                        state_q        <= S_EMIT_X;
                    end
                end

                S_EMIT_X: begin
                    if (sample_ready) begin
                        idx_q        <= idx_q + 10'd1;
                        sample_idx_q <= idx_q + 10'd1;
                        sample_val_q <= y_q;
                        state_q      <= S_EMIT_Y;
                    end
                end

                S_EMIT_Y: begin
                    if (sample_ready) begin
                        sample_valid_q <= 1'b0;
                        idx_q          <= idx_q + 10'd1;
                        pairs_q        <= pairs_q + 9'd1;
                        if (pairs_q + 9'd1 == bv_q) begin
                            state_q <= S_COUNT1;
                        end else begin
                            ht_sel_q <= pick_tbl(idx_q + 10'd1, r1_q, r2_q, t0_q, t1_q, t2_q);
                            state_q  <= S_BIG;
                        end
                    end
                end

                S_COUNT1: begin
                    if (q_exit) begin
                        state_q <= S_ZERO;
                    end else if (q_axiov) begin
                        qbusy_q <= 1'b0;
                        if (overrun) begin
                            state_q <= S_ZERO;
                        end else begin
                            quad_q         <= q_vwxy;
                            qcnt_q         <= 2'd0;
                            sample_valid_q <= 1'b1;
                            sample_idx_q   <= idx_q;
                            sample_val_q   <= sext2(q_vwxy[3]);
                            state_q        <= S_EMIT_Q;
                        end
                    end else if (q_feed) begin
                        qbusy_q <= 1'b1;
                    end
                end

                S_EMIT_Q: begin
                    if (sample_ready) begin
                        idx_q <= idx_q + 10'd1;
                        if (qcnt_q == 2'd3) begin
                            sample_valid_q <= 1'b0;
                            state_q        <= S_COUNT1;
                        end else begin
                            qcnt_q       <= qnext;
                            sample_idx_q <= idx_q + 10'd1;
                            sample_val_q <= sext2(quad_q[2'd3 - qnext]);
                        end
                    end
                end

                S_ZERO: begin
                    // Entered with sample_valid low; the first cycle decides
                    // whether any zero samples remain before finishing.
                    if (!sample_valid_q) begin
                        if (idx_q >= N_SAMP) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            sample_valid_q <= 1'b1;
                            sample_idx_q   <= idx_q;
                            sample_val_q   <= '0;
                        end
                    end else if (sample_ready) begin
                        idx_q <= idx_q + 10'd1;
                        if (idx_q == LAST_IDX) begin
                            sample_valid_q <= 1'b0;
                            done_q         <= 1'b1;
                            state_q        <= S_DONE;
                        end else begin
                            sample_idx_q <= idx_q + 10'd1;
                        end
                    end
                end

                S_DONE: state_q <= S_IDLE;

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_decode_ctrl.sv
module tb_huffman_decode_ctrl;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [8:0]      big_values;
    logic [4:0]      table_sel0, table_sel1, table_sel2;
    logic [9:0]      region1_start, region2_start;
    logic            count1_sel;
    logic [11:0]     part3_len;
    logic            bit_valid, bit_data, bit_ready;
    logic [4:0]      ht_sel;
    logic            ht_axiiv, ht_axiid, ht_axiov;
    logic [15:0]     ht_x, ht_y;
    logic            q_sel, q_axiiv, q_axiid, q_axiov;
    logic [3:0][1:0] q_vwxy;
    logic            sample_valid, sample_ready;
    logic [9:0]      sample_idx;
    logic [15:0]     sample_val;
    logic            done;
    logic [11:0]     bits_used;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    huffman_decode_ctrl #(.NUM_SAMPLES(576), .SAMPLE_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .big_values(big_values),
        .table_sel0(table_sel0), .table_sel1(table_sel1), .table_sel2(table_sel2),
        .region1_start(region1_start), .region2_start(region2_start),
        .count1_sel(count1_sel), .part3_len(part3_len),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
        .ht_sel(ht_sel), .ht_axiiv(ht_axiiv), .ht_axiid(ht_axiid), .ht_axiov(ht_axiov),
        .ht_x(ht_x), .ht_y(ht_y),
        .q_sel(q_sel), .q_axiiv(q_axiiv), .q_axiid(q_axiid), .q_axiov(q_axiov),
        .q_vwxy(q_vwxy),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_idx(sample_idx), .sample_val(sample_val),
        .done(done), .bits_used(bits_used)
    );

    // Bit source: first bit is bvec[0]; cons counts bits taken by the DUT.
    logic [31:0] bvec = '0;
    int nb = 0;
    int base = 0;
    int cons = 0;
    int off;
    always @(posedge clk) if (bit_ready) cons <= cons + 1;
    always_comb begin
        off       = cons - base;
        bit_valid = (off >= 0) && (off < nb);
        bit_data  = ((off >= 0) && (off < 32)) ? bvec[off[4:0]] : 1'b0;
    end

    // Toy pair table: unary code (k zeros then a 1) -> x = k*sel, y = -k.
    logic [4:0] hb_cnt;
    logic       hb_done;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_cnt <= '0; hb_done <= 1'b0;
        end else if (hb_done) begin
            hb_cnt <= '0; hb_done <= 1'b0;
        end else if (ht_axiiv) begin
            if (ht_axiid) hb_done <= 1'b1;
            else          hb_cnt  <= hb_cnt + 5'd1;
        end
    end
    assign ht_axiov = hb_done;
    assign ht_x = hb_done ? 16'(int'(hb_cnt) * int'(ht_sel)) : 16'd0;
    assign ht_y = hb_done ? 16'(-int'(hb_cnt)) : 16'd0;

    // Toy quad table: unary code; fixed pattern per table select.
    logic [4:0] qb_cnt;
    logic       qb_done;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qb_cnt <= '0; qb_done <= 1'b0;
        end else if (qb_done) begin
            qb_cnt <= '0; qb_done <= 1'b0;
        end else if (q_axiiv) begin
            if (q_axiid) qb_done <= 1'b1;
            else         qb_cnt  <= qb_cnt + 5'd1;
        end
    end
    assign q_axiov = qb_done;
    assign q_vwxy  = q_sel ? {2'b01, 2'b11, 2'b00, 2'b01} : {2'b11, 2'b01, 2'b01, 2'b00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_bits(input logic [31:0] v, input int n);
        bvec = v; nb = n; base = cons;
    endtask

    task automatic setup(input logic [8:0] bv, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [9:0] r1, input logic [9:0] r2,
                         input logic c1, input logic [11:0] p3);
        big_values = bv; table_sel0 = a; table_sel1 = b; table_sel2 = c;
        region1_start = r1; region2_start = r2; count1_sel = c1; part3_len = p3;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Waits (bounded) for a presented sample and checks valid/idx/val together.
    task automatic wait_check(input string tag, input int ei, input logic [15:0] ev);
        int n = 0;
        do begin @(negedge clk); n++; end while (!sample_valid && n < 64);
        chk(tag, {5'd0, sample_valid, sample_idx, sample_val}, {5'd0, 1'b1, 10'(ei), ev});
    endtask

    task automatic zero_run(input int from);
        for (int i = from; i < 576; i++) wait_check("zero", i, 16'd0);
        @(negedge clk); chk("done_hi", {31'd0, done}, 32'd1);
        @(negedge clk); chk("done_lo", {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sample_ready = 1'b1;
        setup(9'd0, 5'd0, 5'd0, 5'd0, 10'd0, 10'd0, 1'b0, 12'd0);
        #12;
        chk("rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_outs",  {10'd0, done, bit_ready, ht_sel, sample_idx}, 32'd0);
        chk("rst_bits",  {20'd0, bits_used}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // One pair from table 1 ("1" -> 0,0), budget exhausted, zero-fill.
        setup(9'd1, 5'd1, 5'd1, 5'd1, 10'd576, 10'd576, 1'b0, 12'd1);
        load_bits(32'b1, 1);
        pulse_start();
        chk("s1_htsel", {27'd0, ht_sel}, 32'd1);
        wait_check("s1_x", 0, 16'd0);
        wait_check("s1_y", 1, 16'd0);
        zero_run(2);
        chk("s1_bits", {20'd0, bits_used}, 32'd1);

        // Region switch at idx 2; Y held 5 cycles; start ignored while busy.
        sample_ready = 1'b0;
        setup(9'd2, 5'd1, 5'd2, 5'd3, 10'd2, 10'd576, 1'b0, 12'd5);
        load_bits(32'b10010, 5);
        pulse_start();
        wait_check("s2_x0", 0, 16'd1);
        chk("s2_htsel0", {27'd0, ht_sel}, 32'd1);
        sample_ready = 1'b1;
        wait_check("s2_y0", 1, 16'hFFFF);
        sample_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin start = 1'b1; big_values = 9'd0; end
            if (i == 2) begin start = 1'b0; big_values = 9'd2; end
            chk("s2_hold", {5'd0, sample_valid, sample_idx, sample_val}, {5'd0, 1'b1, 10'd1, 16'hFFFF});
            chk("s2_nofeed", {31'd0, bit_ready}, 32'd0);
        end
        sample_ready = 1'b1;
        wait_check("s2_x1", 2, 16'd4);
        chk("s2_htsel1", {27'd0, ht_sel}, 32'd2);
        wait_check("s2_y1", 3, 16'hFFFE);
        zero_run(4);
        chk("s2_bits", {20'd0, bits_used}, 32'd5);

        // Table 0: 8 zero samples without bit consumption, then one quad.
        setup(9'd4, 5'd0, 5'd0, 5'd0, 10'd576, 10'd576, 1'b0, 12'd2);
        load_bits(32'b10, 2);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            wait_check("s3_t0", i, 16'd0);
            chk("s3_nofeed", {31'd0, bit_ready}, 32'd0);
        end
        wait_check("s3_v", 8, 16'hFFFF);
        wait_check("s3_w", 9, 16'd1);
        wait_check("s3_x", 10, 16'd1);
        wait_check("s3_y", 11, 16'd0);
        zero_run(12);
        chk("s3_bits", {20'd0, bits_used}, 32'd2);

        // Quad completes one bit past the budget: discarded, all zeros.
        setup(9'd0, 5'd1, 5'd1, 5'd1, 10'd576, 10'd576, 1'b1, 12'd1);
        load_bits(32'b10, 2);
        pulse_start();
        zero_run(0);
        chk("s4_bits", {20'd0, bits_used}, 32'd2);

        // Reset in the middle of a codeword, then a clean decode.
        setup(9'd3, 5'd1, 5'd1, 5'd1, 10'd576, 10'd576, 1'b0, 12'd20);
        load_bits(32'b000, 3);
        pulse_start();
        repeat (5) @(negedge clk);
        chk("s5_pre_bits", {20'd0, bits_used}, 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("s5_rst_outs", {10'd0, done, bit_ready, ht_sel, sample_idx}, 32'd0);
        chk("s5_rst_bits", {19'd0, sample_valid, bits_used}, 32'd0);
        @(negedge clk); rst = 1'b0;
        setup(9'd1, 5'd1, 5'd1, 5'd1, 10'd576, 10'd576, 1'b0, 12'd1);
        load_bits(32'b1, 1);
        pulse_start();
        wait_check("s6_x", 0, 16'd0);
        wait_check("s6_y", 1, 16'd0);
        zero_run(2);
        chk("s6_bits", {20'd0, bits_used}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
